float_fixed_scheduler: RTL and testbench

Round-robin scheduler that shares one float-to-fixed converter (IEEE-754 single in, 22-bit fixed out: 1 sign, 1 integer, 20 fraction bits) among NUM_REQ requesters. Each requester hands over one 32-bit float with a valid/ready handshake. The scheduler issues the float to the converter, waits for completion under a watchdog timeout, and returns the tagged result on a single response channel with backpressure. It sits between the converter instance and the client blocks that need fixed-point values.

---
 rtl/float_fixed_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/float_fixed_scheduler.sv | 119 +++++++++++
 tb/tb_float_fixed_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_fixed_pkg.sv
// Shared constants and state encoding for the float-to-fixed request scheduler.
package float_fixed_pkg;

    localparam int FLOAT_W  = 32;
    localparam int FIXED_W  = 22;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t RESP  = 2'd3;

    // Exponent field above the bias means |x| >= 2, inf or NaN: outside the 1.20 range.
    function automatic logic exp_out_of_range(input logic [EXP_MSB-EXP_LSB:0] exp_field);
        return exp_field > 8'(EXP_BIAS);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] sel;

    // Scan from the farthest offset back to ptr so the closest valid requester wins last.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = |req;
        sum     = '0;
        sel     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            sel = sum[IDX_W-1:0];
            if (req[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/float_fixed_scheduler.sv
// Round-robin scheduler sharing one float-to-fixed converter among NUM_REQ clients,
// with a watchdog on converter completion and a backpressured tagged response channel.
module float_fixed_scheduler
    import float_fixed_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*FLOAT_W-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [FIXED_W-1:0]         rsp_result,
    output logic                       rsp_range_err,
    output logic                       rsp_timeout,
    output logic                       conv_enable,
    output logic [FLOAT_W-1:0]         conv_data,
    input  logic                       conv_done,
    input  logic [FIXED_W-1:0]         conv_result,
    output logic                       busy
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic [FLOAT_W-1:0] data_q;
    logic [FIXED_W-1:0] result_q;
    logic               range_err_q;
    logic               timeout_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic [FLOAT_W-1:0] sel_data;
    logic               wait_expired;
    logic [ID_W-1:0]    next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (arb_grant),
        .idx     (arb_idx),
        .any_req (arb_any)
    );

    assign sel_data     = req_data[arb_idx*FLOAT_W +: FLOAT_W];
    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign next_ptr     = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

    // The accept pulse is combinational, so it is also masked while reset is held.
    assign req_ready     = (state == IDLE && rst_n) ? arb_grant : '0;
    assign conv_enable   = (state == ISSUE);
    assign conv_data     = data_q;
    assign rsp_valid     = (state == RESP);
    assign rsp_id        = id_q;
    assign rsp_result    = result_q;
    assign rsp_range_err = range_err_q;
    assign rsp_timeout   = timeout_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            id_q        <= '0;
            wait_cnt    <= '0;
            data_q      <= '0;
            result_q    <= '0;
            range_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        id_q        <= arb_idx;
                        data_q      <= sel_data;
                        range_err_q <= exp_out_of_range(sel_data[EXP_MSB:EXP_LSB]);
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Completion takes priority over the watchdog in the same cycle.
                    wait_cnt <= wait_cnt + 1'b1;
                    if (conv_done) begin
                        result_q  <= conv_result;
                        timeout_q <= 1'b0;
                        state     <= RESP;
                    end else if (wait_expired) begin
                        result_q  <= '0;
                        timeout_q <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_fixed_scheduler.sv
// Bench for float_fixed_scheduler: transaction-level scoreboard plus converter and client models.
module tb_float_fixed_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*32-1:0] req_data = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [ID_W-1:0]       rsp_id;
    logic [21:0]           rsp_result;
    logic                  rsp_range_err;
    logic                  rsp_timeout;
    logic                  conv_enable;
    logic [31:0]           conv_data;
    logic                  conv_done = 1'b0;
    logic [21:0]           conv_result = '0;
    logic                  busy;

    always #5 clk = ~clk;

    float_fixed_scheduler #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_range_err (rsp_range_err),
        .rsp_timeout   (rsp_timeout),
        .conv_enable   (conv_enable),
        .conv_data     (conv_data),
        .conv_done     (conv_done),
        .conv_result   (conv_result),
        .busy          (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard / model state
    int          cyc = 0;
    bit          inflight = 0;
    int          t_acc = 0;
    int          t_id = 0;
    logic [31:0] t_data = '0;
    int          t_d = 1;
    bit          t_spur = 0;
    int          m_ptr = 0;
    logic [NUM_REQ-1:0] seen_rdy = '0;

    // Stimulus knobs
    int          cfg_d = 1;
    bit          auto_req = 0;
    int          p_valid = 0;
    int          p_drop = 0;
    bit          rnd_data = 0;
    logic [31:0] fixed_data = 32'h3F000000;
    bit          rdy_rand = 0;
    int          hold = 0;
    int          n_vcyc = 0;

    // Observations
    int          rsp_cnt = 0;
    int          lr_id = 0;
    logic [21:0] lr_result = '0;
    bit          lr_rerr = 0;
    bit          lr_tout = 0;
    int          lr_lat = 0;
    int          lr_vcyc = 0;
    int          grant_q[$];
    int          rspid_q[$];
    logic [21:0] rspres_q[$];

    // Converter behaviour: 1.20 sign-magnitude, truncating, 0 for exp 0 or exp > 127.
    function automatic logic [21:0] conv_fn(input logic [31:0] f);
        int          e;
        logic [23:0] m;
        logic [23:0] mag;
        e = int'(f[30:23]);
        m = {1'b1, f[22:0]};
        if (e == 0 || e > 127) return 22'd0;
        mag = m >> (130 - e);
        return {f[31], mag[20:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        int          r;
        f = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0)      f[30:23] = 8'd0;
        else if (r == 1) f[30:23] = 8'hFF;
        else if (r < 4)  f[30:23] = 8'(128 + $urandom_range(0, 3));
        else             f[30:23] = 8'(110 + $urandom_range(0, 17));
        return f;
    endfunction

    function automatic logic [31:0] next_data();
        return rnd_data ? rand_float() : fixed_data;
    endfunction

    task automatic monitor();
        logic [NUM_REQ-1:0] exp_rdy;
        int g;
        int lat;
        bit exp_v;
        exp_rdy = '0;
        g = 0;
        if (!inflight && |req_valid) begin
            g = m_ptr;
            while (!req_valid[g]) g = (g + 1) % NUM_REQ;
            exp_rdy[g] = 1'b1;
        end
        seen_rdy = req_ready;
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, inflight);
        chk("conv_enable", conv_enable, inflight && cyc == t_acc + 1);
        if (inflight) begin
            chk("conv_data", conv_data, t_data);
            lat   = (t_d == 0) ? 2 + TIMEOUT : 2 + t_d;
            exp_v = (cyc >= t_acc + 2) && (cyc >= t_acc + lat);
            chk("rsp_valid", rsp_valid, exp_v);
            if (exp_v) begin
                if (n_vcyc == 0) lr_lat = cyc - t_acc;
                n_vcyc++;
                chk("rsp_id", rsp_id, t_id);
                chk("rsp_result", rsp_result, (t_d == 0) ? 22'd0 : conv_fn(t_data));
                chk("rsp_range_err", rsp_range_err, t_data[30:23] > 8'd127);
                chk("rsp_timeout", rsp_timeout, t_d == 0);
                if (rsp_valid && rsp_ready) begin
                    lr_id     = rsp_id;
                    lr_result = rsp_result;
                    lr_rerr   = rsp_range_err;
                    lr_tout   = rsp_timeout;
                    lr_vcyc   = n_vcyc;
                    rspid_q.push_back(int'(rsp_id));
                    rspres_q.push_back(rsp_result);
                    n_vcyc    = 0;
                    rsp_cnt++;
                    m_ptr     = (t_id + 1) % NUM_REQ;
                    inflight  = 0;
                end
            end
        end else begin
            chk("rsp_valid_idle", rsp_valid, 1'b0);
        end
        if (exp_rdy != '0) begin
            for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grant_q.push_back(i);
            inflight = 1;
            t_acc    = cyc;
            t_id     = g;
            t_data   = req_data[g*32 +: 32];
        end
    endtask

    task automatic drive();
        if (inflight && cyc == t_acc) begin
            t_d    = (cfg_d >= 0) ? cfg_d : (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8)));
            t_spur = (cfg_d < 0) && ($urandom_range(0, 3) == 0);
        end
        conv_done   = 1'b0;
        conv_result = 22'($urandom);
        if (inflight && cyc == t_acc && t_spur) conv_done = 1'b1;
        if (inflight && t_d != 0 && cyc == t_acc + t_d) begin
            conv_done   = 1'b1;
            conv_result = conv_fn(t_data);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (seen_rdy[i]) begin
                if (auto_req && $urandom_range(0, 99) < p_valid) req_data[i*32 +: 32] = next_data();
                else req_valid[i] = 1'b0;
            end else if (auto_req) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 99) < p_valid) begin
                        req_valid[i] = 1'b1;
                        req_data[i*32 +: 32] = next_data();
                    end
                end else if ($urandom_range(0, 99) < p_drop) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        seen_rdy  = '0;
        rsp_ready = rdy_rand ? ($urandom_range(0, 99) < 70) : (n_vcyc >= hold);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int k;
        k = 0;
        while (rsp_cnt < target && k < budget) begin
            step();
            k++;
        end
        chk("wait_rsp_in_budget", rsp_cnt >= target, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_id, rsp_result, rsp_range_err,
                            rsp_timeout, conv_enable, busy}, 64'd0);
        chk({tag, "_conv_data"}, conv_data, 64'd0);
    endtask

    task automatic send(input int i, input logic [31:0] f);
        req_data[i*32 +: 32] = f;
        req_valid[i] = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected end before 400000");
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;

        // Single request, 1.5 from requester 2
        cfg_d = 1;
        send(2, 32'h3FC00000);
        wait_rsp(1, 40);
        chk("single_id", lr_id, 2);
        chk("single_result", lr_result, 22'h180000);
        chk("single_flags", {lr_rerr, lr_tout}, 2'b00);
        chk("single_latency", lr_lat, 3);

        // All requesters continuously valid with 0.5; pointer now sits after 2
        auto_req = 1; p_valid = 100; p_drop = 0; rnd_data = 0; fixed_data = 32'h3F000000;
        for (int i = 0; i < NUM_REQ; i++) send(i, 32'h3F000000);
        grant_q.delete();
        rspid_q.delete();
        rspres_q.delete();
        wait_rsp(rsp_cnt + 5, 100);
        auto_req = 0;
        req_valid = '0;
        chk("rr_count", rspid_q.size(), 5);
        if (rspid_q.size() >= 5) begin
            for (int j = 0; j < 5; j++) begin
                chk("rr_order", rspid_q[j], (3 + j) % NUM_REQ);
                chk("rr_result", rspres_q[j], 22'h080000);
            end
        end

        // Backpressure on -1.5 with a competing requester waiting
        step();
        hold = 5;
        send(1, 32'hBFC00000);
        send(3, 32'h3F000000);
        base = rsp_cnt;
        wait_rsp(base + 1, 60);
        chk("bp_id", lr_id, 1);
        chk("bp_result", lr_result, 22'h380000);
        chk("bp_valid_cycles", lr_vcyc, 6);
        hold = 0;
        wait_rsp(base + 2, 60);
        chk("bp_next_id", lr_id, 3);

        // Out-of-range float
        cfg_d = 2;
        send(0, 32'h40000000);
        wait_rsp(rsp_cnt + 1, 40);
        chk("range_result", lr_result, 22'd0);
        chk("range_err", lr_rerr, 1'b1);
        chk("range_tout", lr_tout, 1'b0);

        // Watchdog expiry, then a normal request
        cfg_d = 0;
        send(2, 32'h3F400000);
        wait_rsp(rsp_cnt + 1, 60);
        chk("tout_latency", lr_lat, 2 + TIMEOUT);
        chk("tout_flag", lr_tout, 1'b1);
        chk("tout_result", lr_result, 22'd0);
        cfg_d = 1;
        send(0, 32'h3F000000);
        wait_rsp(rsp_cnt + 1, 40);
        chk("after_tout_id", lr_id, 0);
        chk("after_tout_flag", lr_tout, 1'b0);
        chk("after_tout_result", lr_result, 22'h080000);

        // Reset while waiting on the converter
        cfg_d = 0;
        send(3, 32'h3FC00000);
        k = 0;
        while (!(inflight && cyc >= t_acc + 5) && k < 40) begin
            step();
            k++;
        end
        chk("reached_wait", inflight && cyc >= t_acc + 5, 1'b1);
        base = rsp_cnt;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_reset");
        inflight  = 0;
        m_ptr     = 0;
        n_vcyc    = 0;
        conv_done = 1'b0;
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("no_rsp_after_reset", rsp_cnt, base);
        cfg_d = 1;
        grant_q.delete();
        send(1, 32'h3F000000);
        send(3, 32'hBF000000);
        wait_rsp(base + 2, 60);
        chk("post_reset_grants", grant_q.size(), 2);
        if (grant_q.size() >= 2) begin
            chk("post_reset_first", grant_q[0], 1);
            chk("post_reset_second", grant_q[1], 3);
        end

        // Randomised traffic
        base = rsp_cnt;
        cfg_d = -1; auto_req = 1; p_valid = 40; p_drop = 10; rnd_data = 1; rdy_rand = 1;
        repeat (1500) step();
        auto_req = 0;
        req_valid = '0;
        rdy_rand = 0;
        k = 0;
        while (inflight && k < 100) begin
            step();
            k++;
        end
        chk("random_drained", inflight, 1'b0);
        chk("random_activity", rsp_cnt > base + 20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
